// File: rtl/output_block_if.sv
// Bus bundle for the timer output stage: the control inputs from the timer core
// and the waveform/status outputs back from the output block.
interface output_block_if #(
  parameter int CW = 8
);
  logic          tick;
  logic          en;
  logic [1:0]    mode;
  logic [CW-1:0] period;
  logic [CW-1:0] duty;
  logic          inv;
  logic          start;
  logic          clk_out;
  logic          busy;
  logic          cycle_done;

  // Timer core side: drives configuration and ticks, observes the waveform.
  modport master (
    output tick, en, mode, period, duty, inv, start,
    input  clk_out, busy, cycle_done
  );

  // Output block side.
  modport slave (
    input  tick, en, mode, period, duty, inv, start,
    output clk_out, busy, cycle_done
  );
endinterface

// File: rtl/output_block.sv
// Timer output stage: turns the prescaled tick stream into a waveform on clk_out
// (off / toggle-on-match / one-shot / PWM). Mode, period and duty are shadowed and
// only change on enable or at a counter wrap so a running period is never torn.
// Optional feature macro WAVE_HOLD_EN: every clk_out level is held for at least
// MIN_HOLD clk cycles so a sampling edge detector downstream cannot miss it.
module output_block #(
  parameter int CW       = 8,
  parameter int MIN_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  output_block_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_TOGGLE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_PWM     = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  if (MIN_HOLD < 1) begin : g_bad_min_hold
    $error("output_block: MIN_HOLD must be at least 1");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tog_q, tog_d;
  logic          done_q, done_d;
  logic          en_q;
  mode_e         mode_s;
  logic [CW-1:0] period_s;
  logic [CW-1:0] duty_s;
  logic          load_s;
  logic          wrap;
  logic          run;
  logic          wave;
  logic          target;
  logic          clk_out_q;

  // Next-state logic: counter, toggle flop, one-shot FSM and shadow-load strobe.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    wrap    = bus.tick && (cnt_q == period_s);

    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      tog_d   = 1'b0;
    end else if (!en_q) begin
      // First enabled cycle: capture configuration, start from a clean count.
      load_s  = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      tog_d   = 1'b0;
    end else begin
      unique case (mode_s)
        MODE_OFF: begin
          state_d = IDLE;
          cnt_d   = '0;
          tog_d   = 1'b0;
        end
        MODE_TOGGLE, MODE_PWM: begin
          if (wrap) begin
            cnt_d  = '0;
            done_d = 1'b1;
            load_s = 1'b1;
            if (mode_s == MODE_TOGGLE) tog_d = ~tog_q;
          end else if (bus.tick) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MODE_ONESHOT: begin
          unique case (state_q)
            IDLE: begin
              cnt_d = '0;
              if (bus.start) state_d = RUN;
            end
            RUN: begin
              // A start arriving here, even on the end tick, is ignored.
              if (wrap) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                load_s  = 1'b1;
              end else if (bus.tick) begin
                cnt_d = cnt_q + 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

  // Raw waveform level for the active mode, then polarity; idle level is inv.
  always_comb begin
    wave = 1'b0;
    run  = bus.en && en_q;
    case (mode_s)
      MODE_TOGGLE:  wave = tog_q;
      MODE_PWM:     wave = (cnt_q < duty_s);
      MODE_ONESHOT: wave = (state_q == RUN);
      default:      wave = 1'b0;
    endcase
    target = (run && wave) ^ bus.inv;
  end

  // State, counter and shadow registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      // NOTE: only a handful of control flops here, so every one is reset explicitly.
      state_q  <= IDLE;
      cnt_q    <= '0;
      tog_q    <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      mode_s   <= MODE_OFF;
      period_s <= '0;
      duty_s   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      done_q  <= done_d;
      en_q    <= bus.en;
      if (load_s) begin
        mode_s   <= mode_e'(bus.mode);
        period_s <= bus.period;
        duty_s   <= bus.duty;
      end
    end
  end

`ifdef WAVE_HOLD_EN
  localparam int            HW       = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD - 1);

  logic [HW-1:0] hold_q;

  // Output register with minimum level hold; the latest pending level wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_out_q <= 1'b0;
      hold_q    <= HOLD_MAX;
    end else if ((target != clk_out_q) && (hold_q == HOLD_MAX)) begin
      clk_out_q <= target;
      hold_q    <= '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_q <= hold_q + 1'b1;
    end
  end
`else
  // Output register: clk_out follows the polarity-adjusted level one clk later.
  always_ff @(posedge clk) begin
    if (rst) clk_out_q <= 1'b0;
    else     clk_out_q <= target;
  end
`endif

  assign bus.clk_out    = clk_out_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.cycle_done = done_q;

endmodule
